// File: rtl/text_write_arbiter.sv
// Sole owner of the text buffer write port: shares one write per cycle between
// the full-buffer clear, the menu cursor erase/draw and queued config writes.
module text_write_arbiter #(
  parameter int         ADDR_W      = 10,
  parameter int         BUF_DEPTH   = 1024,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20,
  parameter logic [7:0] CURSOR_CHAR = 8'h3E,
  parameter int         CURSOR_BASE = 2,
  parameter int         ROW_STRIDE  = 80,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cfg_valid_in,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [7:0]        cfg_data_in,
  input  logic [3:0]        ptr_index_in,
  input  logic              clear_in,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [7:0]        mem_data_out,
  output logic              busy_out,
  output logic              overflow_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WIDE_W = ADDR_W + 4;

  typedef enum logic [1:0] {CLEAR, CURSOR_DRAW, CURSOR_ERASE, IDLE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } cfg_entry_t;

  state_t            state;
  logic [ADDR_W-1:0] clear_cnt;
  logic [3:0]        drawn_ptr;

  cfg_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  cfg_entry_t        head;
  logic [ADDR_W-1:0] draw_addr;
  logic [ADDR_W-1:0] erase_addr;

  // Rows past the end of the buffer simply wrap; the menu never asks for them.
  function automatic logic [ADDR_W-1:0] cursor_addr(input logic [3:0] row);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(CURSOR_BASE) + WIDE_W'(row) * WIDE_W'(ROW_STRIDE);
    return wide[ADDR_W-1:0];
  endfunction

  assign draw_addr  = cursor_addr(ptr_index_in);
  assign erase_addr = cursor_addr(drawn_ptr);

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  // Config writes only get the port when nothing of higher priority wants it.
  assign pop  = (state == IDLE) && !clear_in && (ptr_index_in == drawn_ptr) && !fifo_empty;
  assign push = cfg_valid_in && (!fifo_full || pop);

  assign busy_out = (state != IDLE) || !fifo_empty;

  // NOTE: queue storage has no reset; the pointers alone define what is valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: cfg_addr_in, data: cfg_data_in};
  end

  // NOTE: every register here uses non-blocking assignment so all decisions in
  // a cycle see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= CLEAR;
      clear_cnt    <= '0;
      drawn_ptr    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      mem_we_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
      overflow_out <= 1'b0;
    end else begin
      mem_we_out <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (cfg_valid_in && !push) overflow_out <= 1'b1;

      unique case (state)
        CLEAR: begin
          mem_we_out   <= 1'b1;
          mem_addr_out <= clear_cnt;
          mem_data_out <= CLEAR_CHAR;
          clear_cnt    <= clear_cnt + ADDR_W'(1);
          if (clear_cnt == ADDR_W'(BUF_DEPTH - 1)) begin
            clear_cnt <= '0;
            state     <= CURSOR_DRAW;
          end
        end
        CURSOR_DRAW: begin
          mem_we_out   <= 1'b1;
          mem_addr_out <= draw_addr;
          mem_data_out <= CURSOR_CHAR;
          drawn_ptr    <= ptr_index_in;
          clear_cnt    <= '0;
          state        <= clear_in ? CLEAR : IDLE;
        end
        CURSOR_ERASE: begin
          mem_we_out   <= 1'b1;
          mem_addr_out <= erase_addr;
          mem_data_out <= CLEAR_CHAR;
          clear_cnt    <= '0;
          state        <= clear_in ? CLEAR : CURSOR_DRAW;
        end
        IDLE: begin
          if (clear_in) begin
            clear_cnt <= '0;
            state     <= CLEAR;
          end else if (ptr_index_in != drawn_ptr) begin
            state <= CURSOR_ERASE;
          end else if (pop) begin
            mem_we_out   <= 1'b1;
            mem_addr_out <= head.addr;
            mem_data_out <= head.data;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/text_write_arbiter.md
# text_write_arbiter

Owns the single write port of the menu/character text buffer and shares it between three requesters: a full-buffer clear sequencer, the menu cursor updater, and the configuration value writes issued by the config menu. Config writes arrive as one-cycle pulses with no backpressure, so they are queued in a small FIFO and drained when the port is free. Sits between the config menu logic and the text BRAM write port.

## Interface
- ADDR_W, 10, text buffer address width
- BUF_DEPTH, 1024, number of buffer cells cleared (addresses 0..BUF_DEPTH-1)
- CLEAR_CHAR, 8'h20, fill character for clear and cursor erase
- CURSOR_CHAR, 8'h3E, cursor glyph
- CURSOR_BASE, 2, buffer address of cursor for ptr 0
- ROW_STRIDE, 80, address step per menu row
- FIFO_DEPTH, 4, config write queue depth (power of 2)

- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- cfg_valid_in  input  1  one-cycle config write request
- cfg_addr_in  input  ADDR_W  config write address
- cfg_data_in  input  8  config write data
- ptr_index_in  input  4  current menu row selected
- clear_in  input  1  request full buffer clear (pulse)
- mem_we_out  output  1  buffer write enable
- mem_addr_out  output  ADDR_W  buffer write address
- mem_data_out  output  8  buffer write data
- busy_out  output  1  state != IDLE or FIFO non-empty
- overflow_out  output  1  sticky: a config write was dropped

## Operation
- One clock; reset synchronous, active-low; one buffer write per cycle max.
- States: CLEAR, CURSOR_DRAW, CURSOR_ERASE, IDLE.
- Reset (rst_in=0): state CLEAR, clear counter 0, FIFO empty, drawn_ptr 0, mem_we_out 0, mem_addr_out 0, mem_data_out 0, overflow_out 0; busy_out 1.
- CLEAR: write CLEAR_CHAR at counter, counter+1; after address BUF_DEPTH-1 go CURSOR_DRAW. clear_in ignored while in CLEAR.
- CURSOR_DRAW: write CURSOR_CHAR at CURSOR_BASE + ptr*ROW_STRIDE (ptr = ptr_index_in sampled this cycle), drawn_ptr <= ptr, go IDLE.
- IDLE priority: clear_in -> CLEAR (counter 0, no write this cycle); else ptr_index_in != drawn_ptr -> CURSOR_ERASE (no write this cycle); else FIFO non-empty -> pop head and write it, stay IDLE; else no write.
- CURSOR_ERASE: write CLEAR_CHAR at CURSOR_BASE + drawn_ptr*ROW_STRIDE, go CURSOR_DRAW.
- clear_in in CURSOR_ERASE/CURSOR_DRAW: current write completes, next state CLEAR.
- Cursor address arithmetic in ADDR_W+4 bits, truncated to ADDR_W; no range check on ptr.
- FIFO: push on cfg_valid_in in any state. Full and no pop same cycle -> drop, overflow_out <= 1 until reset. Full with pop same cycle -> push accepted. FIFO contents survive clear_in (not reset).
- Config writes drain in arrival order.

## Timing
- All mem_* outputs registered: decision in cycle N, mem_we_out high in N+1.
- mem_we_out deasserted (0) in every cycle without a write; mem_addr_out/mem_data_out hold last value.
- After reset release (first cycle rst_in=1 is cycle 0): clear writes in cycles 1..BUF_DEPTH, addresses 0..BUF_DEPTH-1; cursor draw in cycle BUF_DEPTH+1.
- Config write into empty FIFO in IDLE, no cursor work: cfg_valid_in in cycle N -> mem_we_out high in N+2.
- Cursor move: ptr change seen in IDLE cycle N -> erase write in N+2, draw write in N+3; a further ptr change during this is handled by a new erase/draw pair.
- Queued FIFO entries drain back-to-back, one per cycle.
- busy_out combinational from state and FIFO count.

## Test plan
- Reset with ptr_index_in=0 -> 1024 writes of 8'h20 at addresses 0..1023 in order, then one write 8'h3E at address 2; busy_out falls next cycle.
- Idle, cfg pulse addr 219 data 3 in cycle N -> single write (219, 3) in cycle N+2; no other writes.
- Five cfg pulses in consecutive cycles during CLEAR -> first four written in order after cursor draw, fifth dropped, overflow_out=1 and stays 1 until rst_in=0.
- Idle, ptr_index_in 0->12 -> write (2, 8'h20) then (962, 8'h3E) on consecutive cycles.
- ptr change and cfg pulse same cycle -> erase, draw, then cfg write; total three writes.
- clear_in during CURSOR_ERASE with one queued cfg write -> erase completes, full 1024-cell clear, cursor draw at current ptr, then queued cfg write.
